sd_read_arbiter: RTL and testbench
==================================

Name: sd_read_arbiter

Overview:
- Shares the single SD read engine (sd_control read port) among N_REQ requesters, e.g. the asset loader, the save/debug reader and the hex-display debug path.
- Grants are round-robin. Each grant runs a four-phase handshake: sd_read is held high until sd_read_done, then dropped, then the block waits for done to clear.
- A watchdog bounds each transaction. The requester gets a one-cycle ack with the data or an error flag.
- Sits between the requesters and sd_control, on the SD_CLK domain.

Parameters:
- N_REQ, 2, number of requesters (1..8).
- TIMEOUT_CYCLES, 1048575, clk cycles allowed from grant to done-low before abort.
- CNT_W, 20, watchdog counter width; must hold TIMEOUT_CYCLES.

Ports:
- clk  input  1  SD clock domain (the SD_CLK net).
- reset  input  1  asynchronous, active-high; all state cleared immediately.
- req  input  N_REQ  level request per requester; held with req_addr until its ack.
- req_addr  input  32*N_REQ  byte address per requester; slice i is [32*i+31:32*i].
- ack  output  N_REQ  one-cycle pulse on completion for the granted requester.
- ack_err  output  1  valid with ack: 1 means timeout or init lost.
- rd_data  output  32  valid with ack; 0 when ack_err=1.
- busy  output  1  high in any state other than IDLE/WAIT_INIT.
- grant_id  output  3  index of the current or last granted requester.
- sd_init_done  input  1  from sd_control.
- sd_read  output  1  read strobe to sd_control, level.
- sd_addr  output  32  address to sd_control; stable while sd_read=1.
- sd_read_done  input  1  level; stays high until sd_read falls.
- sd_data  input  32  read data; valid while sd_read_done=1.

Behaviour:
- Reset values: all outputs 0. State=WAIT_INIT, rr pointer=0, watchdog=0.
- WAIT_INIT: stay until sd_init_done=1, then go to IDLE. Requests are ignored meanwhile; no ack.
- IDLE: if any req bit is set, pick the first set bit searching upward from rr pointer, wrapping at N_REQ.
  - Latch its index into grant_id and its address into sd_addr.
  - Set rr pointer = index+1 mod N_REQ.
  - Go to ISSUE. The decision takes 1 cycle; sd_read rises the next cycle.
- ISSUE: sd_read=1.
  - If sd_read_done=1, capture sd_data into rd_data, drop sd_read and go to DRAIN.
- DRAIN: sd_read=0.
  - If sd_read_done=0, go to ACK.
- ACK: ack[grant_id]=1 for exactly one cycle, with ack_err and rd_data valid; then go to IDLE.
  - Earliest re-grant is the cycle after ACK. With a done that responds in 1 cycle, request-to-ack is 4 cycles minimum.
- Watchdog:
  - Cleared on entering ISSUE; increments each cycle in ISSUE or DRAIN.
  - On reaching TIMEOUT_CYCLES: drop sd_read, set ack_err=1 and rd_data=0, go to ABORT.
  - ABORT waits for sd_read_done=0, then goes to ACK.
  - A second timeout in ABORT forces ACK anyway.
- Init loss: sd_init_done=0 in ISSUE, DRAIN or ABORT drops sd_read at once and sets ack_err=1, rd_data=0.
  - The block then pulses ack and goes to WAIT_INIT instead of IDLE.
- Simultaneous requests: only one is granted per transaction. Fairness means a continuously asserted requester waits at most N_REQ-1 transactions.
- A req that drops before ack is a protocol violation. The transaction still completes and the ack still pulses.
- req_addr changes after grant have no effect, because sd_addr is latched.
- Reset mid-transaction: outputs go to 0 asynchronously (sd_read included) and state returns to WAIT_INIT. No ack is issued.
- At most one ack bit is high at any time; ack is never high outside the ACK state.

Test Plan:
- Init gating: req=01 with sd_init_done=0 for 50 cycles -> sd_read stays 0 and no ack. Raise init_done -> grant to 0 and sd_read rises 2 cycles later.
- Single read: req0, addr 0x00000204; model done 3 cycles after sd_read with sd_data=0xDEADBEEF -> sd_addr=0x204, ack=01 once, rd_data=0xDEADBEEF, ack_err=0.
- Round-robin: req=11 held for 4 transactions -> grant order 0,1,0,1; ack bits never overlap.
- Timeout: TIMEOUT_CYCLES=16 and done never asserts -> sd_read falls after 16 cycles in ISSUE; ack pulses with ack_err=1 and rd_data=0; the next request is served normally.
- Init loss: drop sd_init_done during DRAIN -> ack_err=1 ack, state goes to WAIT_INIT, and no further sd_read until init_done=1.
- Async reset: assert reset mid-ISSUE, off the clock edge -> sd_read=0 and busy=0 immediately, no ack; after release the block waits for init_done.

Source files
------------

// File: rtl/sd_read_arbiter.sv
// Round-robin arbiter sharing the single sd_control read port among N_REQ requesters.
// Four-phase handshake per grant, bounded by a watchdog; one-cycle ack with data or error.
module sd_read_arbiter #(
    parameter int unsigned N_REQ          = 2,
    parameter int unsigned TIMEOUT_CYCLES = 1048575,
    parameter int unsigned CNT_W          = 20
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic [32*N_REQ-1:0]  req_addr,
    output logic [N_REQ-1:0]     ack,
    output logic                 ack_err,
    output logic [31:0]          rd_data,
    output logic                 busy,
    output logic [2:0]           grant_id,
    input  logic                 sd_init_done,
    output logic                 sd_read,
    output logic [31:0]          sd_addr,
    input  logic                 sd_read_done,
    input  logic [31:0]          sd_data
);

    typedef enum logic [2:0] {
        StWaitInit,
        StIdle,
        StIssue,
        StDrain,
        StAbort,
        StAck
    } state_e;

    localparam logic [CNT_W-1:0] WdLast = CNT_W'(TIMEOUT_CYCLES - 1);

    state_e           state;
    logic [2:0]       rr_ptr;
    logic [CNT_W-1:0] wd_cnt;
    logic             init_lost;

    logic             pick_valid;
    logic [2:0]       pick_idx;
    logic [31:0]      pick_addr;
    logic [2:0]       cand;
    logic [7:0]       req_pad;
    logic [N_REQ-1:0] ack_onehot;
    logic             wd_expired;

    assign req_pad    = 8'(req);
    assign ack_onehot = N_REQ'(8'b1 << grant_id);
    assign wd_expired = (wd_cnt == WdLast);
    assign busy       = (state != StIdle) && (state != StWaitInit);

    // Descending scan so the candidate closest to rr_ptr is the one left standing.
    always_comb begin
        pick_valid = 1'b0;
        pick_idx   = '0;
        pick_addr  = '0;
        cand       = '0;
        for (int i = int'(N_REQ) - 1; i >= 0; i--) begin
            cand = 3'((int'(rr_ptr) + i) % int'(N_REQ));
            if (req_pad[cand]) begin
                pick_valid = 1'b1;
                pick_idx   = cand;
            end
        end
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (pick_idx == 3'(i)) pick_addr = req_addr[32*i +: 32];
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= StWaitInit;
            rr_ptr    <= '0;
            wd_cnt    <= '0;
            init_lost <= 1'b0;
            ack       <= '0;
            ack_err   <= 1'b0;
            rd_data   <= '0;
            grant_id  <= '0;
            sd_read   <= 1'b0;
            sd_addr   <= '0;
        end else begin
            ack <= '0;
            case (state)
                StWaitInit: begin
                    if (sd_init_done) state <= StIdle;
                end
                StIdle: begin
                    if (pick_valid) begin
                        grant_id  <= pick_idx;
                        sd_addr   <= pick_addr;
                        rr_ptr    <= 3'((int'(pick_idx) + 1) % int'(N_REQ));
                        wd_cnt    <= '0;
                        ack_err   <= 1'b0;
                        init_lost <= 1'b0;
                        sd_read   <= 1'b1;
                        state     <= StIssue;
                    end
                end
                StIssue, StDrain: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (!sd_init_done) begin
                        sd_read   <= 1'b0;
                        ack_err   <= 1'b1;
                        rd_data   <= '0;
                        init_lost <= 1'b1;
                        ack       <= ack_onehot;
                        state     <= StAck;
                    end else if (state == StIssue && sd_read_done) begin
                        rd_data <= sd_data;
                        sd_read <= 1'b0;
                        state   <= StDrain;
                    end else if (state == StDrain && !sd_read_done) begin
                        ack   <= ack_onehot;
                        state <= StAck;
                    end else if (wd_expired) begin
                        sd_read <= 1'b0;
                        ack_err <= 1'b1;
                        rd_data <= '0;
                        wd_cnt  <= '0;
                        state   <= StAbort;
                    end
                end
                StAbort: begin
                    wd_cnt <= wd_cnt + 1'b1;
                    if (!sd_init_done) begin
                        init_lost <= 1'b1;
                        ack       <= ack_onehot;
                        state     <= StAck;
                    end else if (!sd_read_done || wd_expired) begin
                        // A second expiry forces completion even if done stays stuck high.
                        ack   <= ack_onehot;
                        state <= StAck;
                    end
                end
                StAck: begin
                    state <= init_lost ? StWaitInit : StIdle;
                end
                default: state <= StWaitInit;
            endcase
        end
    end

endmodule

// File: tb/tb_sd_read_arbiter.sv
// Directed bench for sd_read_arbiter with an SD read-engine model and an ack scoreboard.
module tb_sd_read_arbiter;

    localparam int N = 2;

    typedef struct packed {
        logic [2:0]  id;
        logic        err;
        logic [31:0] data;
    } exp_t;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req;
    logic [32*N-1:0] req_addr;
    logic [N-1:0]    ack;
    logic            ack_err;
    logic [31:0]     rd_data;
    logic            busy;
    logic [2:0]      grant_id;
    logic            sd_init_done;
    logic            sd_read;
    logic [31:0]     sd_addr;
    logic            sd_read_done;
    logic [31:0]     sd_data;

    int          vectors = 0;
    int          miscompares = 0;
    exp_t        exp_q[$];
    logic        model_en;
    logic        hold_done;
    int          done_delay;
    int          model_cnt;
    logic [31:0] model_xor;

    sd_read_arbiter #(
        .N_REQ          (N),
        .TIMEOUT_CYCLES (16),
        .CNT_W          (8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .req          (req),
        .req_addr     (req_addr),
        .ack          (ack),
        .ack_err      (ack_err),
        .rd_data      (rd_data),
        .busy         (busy),
        .grant_id     (grant_id),
        .sd_init_done (sd_init_done),
        .sd_read      (sd_read),
        .sd_addr      (sd_addr),
        .sd_read_done (sd_read_done),
        .sd_data      (sd_data)
    );

    always #5 clk = ~clk;

    // SD read engine: done done_delay cycles after sd_read rises, drops after sd_read falls.
    always @(posedge clk or posedge reset) begin
        if (reset) begin
            sd_read_done <= 1'b0;
            model_cnt    <= 0;
        end else if (sd_read && !sd_read_done && model_en) begin
            if (model_cnt == done_delay - 1) sd_read_done <= 1'b1;
            model_cnt <= model_cnt + 1;
        end else if (!sd_read && !hold_done) begin
            sd_read_done <= 1'b0;
            model_cnt    <= 0;
        end
    end

    assign sd_data = sd_read_done ? (model_xor ^ sd_addr) : 32'h0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (!reset && ack != '0) begin
            chk("ack_onehot", 32'($onehot(ack)), 32'd1);
            if (exp_q.size() == 0) begin
                chk("unexpected_ack", 32'(ack), 32'd0);
            end else begin
                e = exp_q.pop_front();
                chk("ack_vec", 32'(ack), 32'(2'b01 << e.id));
                chk("ack_grant_id", 32'(grant_id), 32'(e.id));
                chk("ack_err", 32'(ack_err), 32'(e.err));
                chk("rd_data", rd_data, e.data);
            end
        end
    end

    task automatic push(input int id, input logic err, input logic [31:0] data);
        exp_t e;
        e.id   = 3'(id);
        e.err  = err;
        e.data = data;
        exp_q.push_back(e);
    endtask

    task automatic wait_ack(input string tag);
        int n = 0;
        while (ack == '0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({tag, "_ack_seen"}, 32'(ack != '0), 32'd1);
    endtask

    task automatic do_read(input int id, input logic [31:0] addr, input string tag);
        req[id] = 1'b1;
        req_addr[32*id +: 32] = addr;
        push(id, 1'b0, model_xor ^ addr);
        wait_ack(tag);
        req[id] = 1'b0;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout observed=running expected=finished");
        $fatal(1, "bench did not finish");
    end

    initial begin
        int   n;
        int   hi_cnt;
        int   n_acks;
        logic seen;

        reset        = 1'b1;
        req          = '0;
        req_addr     = '0;
        sd_init_done = 1'b0;
        model_en     = 1'b1;
        hold_done    = 1'b0;
        done_delay   = 3;
        model_xor    = 32'hDEADBEEF ^ 32'h204;
        #1;
        chk("rst_ack", 32'(ack), 0);
        chk("rst_ack_err", 32'(ack_err), 0);
        chk("rst_rd_data", rd_data, 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_grant_id", 32'(grant_id), 0);
        chk("rst_sd_read", 32'(sd_read), 0);
        chk("rst_sd_addr", sd_addr, 0);
        @(negedge clk);
        reset = 1'b0;

        // Init gating.
        req[0] = 1'b1;
        req_addr[31:0] = 32'h100;
        push(0, 1'b0, model_xor ^ 32'h100);
        seen = 1'b0;
        repeat (50) begin
            @(negedge clk);
            seen = seen | sd_read | (ack != '0);
        end
        chk("gate_no_activity", 32'(seen), 0);
        sd_init_done = 1'b1;
        @(posedge clk); #1;
        chk("gate_sd_read_1cyc", 32'(sd_read), 0);
        @(posedge clk); #1;
        chk("gate_sd_read_2cyc", 32'(sd_read), 1);
        chk("gate_grant_id", 32'(grant_id), 0);
        @(negedge clk);
        wait_ack("gate");
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Single read with address check while sd_read is high.
        req[0] = 1'b1;
        req_addr[31:0] = 32'h204;
        push(0, 1'b0, 32'hDEADBEEF);
        n = 0;
        while (!sd_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("single_sd_addr", sd_addr, 32'h204);
        wait_ack("single");
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Timeout: done never arrives.
        model_en = 1'b0;
        req[0] = 1'b1;
        req_addr[31:0] = 32'h500;
        push(0, 1'b1, 32'h0);
        hi_cnt = 0;
        n = 0;
        while (n < 100) begin
            @(negedge clk);
            n++;
            if (sd_read) hi_cnt++;
            else if (hi_cnt > 0) break;
        end
        chk("timeout_len", 32'(hi_cnt), 32'd16);
        wait_ack("timeout");
        req[0] = 1'b0;
        model_en = 1'b1;
        repeat (2) @(negedge clk);
        do_read(1, 32'h600, "after_timeout");

        // Round-robin with both requesters held for four transactions.
        req_addr = {32'h2000, 32'h1000};
        push(0, 1'b0, model_xor ^ 32'h1000);
        push(1, 1'b0, model_xor ^ 32'h2000);
        push(0, 1'b0, model_xor ^ 32'h1000);
        push(1, 1'b0, model_xor ^ 32'h2000);
        req = 2'b11;
        n_acks = 0;
        n = 0;
        while (n_acks < 4 && n < 400) begin
            @(negedge clk);
            n++;
            if (ack != '0) n_acks++;
        end
        req = 2'b00;
        chk("rr_ack_count", 32'(n_acks), 32'd4);
        repeat (3) @(negedge clk);

        // Init loss while in DRAIN.
        hold_done = 1'b1;
        req[0] = 1'b1;
        req_addr[31:0] = 32'h700;
        push(0, 1'b1, 32'h0);
        n = 0;
        while (!(busy && !sd_read && sd_read_done) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("loss_reached_drain", 32'(busy && !sd_read && sd_read_done), 1);
        sd_init_done = 1'b0;
        wait_ack("loss");
        req[0] = 1'b0;
        @(negedge clk);
        req[0] = 1'b1;
        req_addr[31:0] = 32'h40;
        push(0, 1'b0, model_xor ^ 32'h40);
        seen = 1'b0;
        repeat (20) begin
            @(negedge clk);
            seen = seen | sd_read | busy;
        end
        chk("loss_waits_init", 32'(seen), 0);
        hold_done = 1'b0;
        sd_init_done = 1'b1;
        wait_ack("loss_recover");
        req[0] = 1'b0;
        repeat (2) @(negedge clk);

        // Asynchronous reset in the middle of ISSUE.
        req[1] = 1'b1;
        req_addr[63:32] = 32'h300;
        n = 0;
        while (!sd_read && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("arst_issue_reached", 32'(sd_read), 1);
        #3;
        reset = 1'b1;
        sd_init_done = 1'b0;
        #1;
        chk("arst_sd_read", 32'(sd_read), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_ack", 32'(ack), 0);
        exp_q.delete();
        @(negedge clk);
        reset = 1'b0;
        seen = 1'b0;
        repeat (10) begin
            @(negedge clk);
            seen = seen | sd_read | (ack != '0);
        end
        chk("arst_waits_init", 32'(seen), 0);
        push(1, 1'b0, model_xor ^ 32'h300);
        sd_init_done = 1'b1;
        wait_ack("arst_recover");
        req[1] = 1'b0;
        repeat (3) @(negedge clk);

        chk("scoreboard_empty", 32'(exp_q.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
